// File: rtl/three_bit_divider.sv
// three_bit_divider: sequential restoring divider, 6-bit dividend / 3-bit divisor.
// Produces one quotient bit per clock. Operands are captured on a START/DONE handshake.
// Optional feature macro: DIV0_SHORTCUT_EN. When it is defined, a zero divisor finishes
// after one edge with Q=6'h3F, REM=0, DIV0=1. When it is not defined, a zero divisor
// runs all iterations and DIV0 is tied low.
module three_bit_divider (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [5:0] N,
    input  logic [2:0] D,
    output logic [5:0] Q,
    output logic [2:0] REM,
    output logic       BUSY,
    output logic       DONE,
    output logic       DIV0
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    // Partial remainder. Its top bit is provably zero after every iteration
    // (the value is always below the divisor), so only three bits are stored.
    logic [2:0] p;
    logic [5:0] ns;
    logic [2:0] dl;
    logic [2:0] cnt;
    logic [5:0] q_reg;
    logic [2:0] rem_reg;

    logic       accept;
    logic       div0_skip;
    logic [3:0] t;
    logic [2:0] diff;
    logic       q_bit;
    logic [2:0] p_next;

    assign accept = START && ((state == S_IDLE) || (state == S_DONE));

`ifdef DIV0_SHORTCUT_EN
    logic       div0_reg;
    assign div0_skip = (state == S_RUN) && (dl == 3'd0);
    assign BUSY      = (state == S_RUN) && (dl != 3'd0);
    assign DIV0      = div0_reg;
`else
    assign div0_skip = 1'b0;
    assign BUSY      = (state == S_RUN);
    assign DIV0      = 1'b0;
`endif

    assign DONE = (state == S_DONE);
    assign Q    = q_reg;
    assign REM  = rem_reg;

    // One restoring step: shift in the next dividend bit and subtract when it fits.
    // A successful subtract leaves a result below 8, so three bits of difference suffice.
    always_comb begin
        t      = {p, ns[5]};
        diff   = t[2:0] - dl;
        q_bit  = 1'b0;
        p_next = t[2:0];
        if (t >= {1'b0, dl}) begin
            q_bit  = 1'b1;
            p_next = diff;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN lasts six edges (or one with the zero-divisor shortcut).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = S_RUN;
            end
            S_RUN: begin
                if (div0_skip || (cnt == 3'd5)) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = accept ? S_RUN : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration shift/subtract, and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p       <= 3'd0;
            ns      <= 6'd0;
            dl      <= 3'd0;
            cnt     <= 3'd0;
            q_reg   <= 6'd0;
            rem_reg <= 3'd0;
`ifdef DIV0_SHORTCUT_EN
            div0_reg <= 1'b0;
`endif
        end else if (accept) begin
            p   <= 3'd0;
            ns  <= N;
            dl  <= D;
            cnt <= 3'd0;
        end else if (state == S_RUN) begin
            if (div0_skip) begin
                q_reg   <= 6'h3F;
                rem_reg <= 3'd0;
`ifdef DIV0_SHORTCUT_EN
                div0_reg <= 1'b1;
`endif
            end else begin
                p   <= p_next;
                ns  <= {ns[4:0], q_bit};
                cnt <= cnt + 3'd1;
                if (cnt == 3'd5) begin
                    q_reg   <= {ns[4:0], q_bit};
                    rem_reg <= p_next;
`ifdef DIV0_SHORTCUT_EN
                    div0_reg <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_three_bit_divider.sv
// Testbench for three_bit_divider: table vectors, handshake/timing sequences,
// exhaustive nonzero-divisor sweep and randomized operands against an arithmetic model.
module tb_three_bit_divider;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [5:0] N     = 6'd0;
    logic [2:0] D     = 3'd0;
    logic [5:0] Q;
    logic [2:0] REM;
    logic       BUSY;
    logic       DONE;
    logic       DIV0;

    int checks = 0;
    int errors = 0;

    int r_q, r_rem, r_div0, r_lat;

    typedef struct {
        int n;
        int d;
        int q;
        int rem;
        int div0;
        int lat;
    } vec_t;

    vec_t vecs[7];

    three_bit_divider dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .REM   (REM),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DIV0  (DIV0)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor behaviour of each build.
    function automatic void model(input int n, input int d,
                                  output int q, output int r, output int z, output int lat);
        if (d == 0) begin
            q = 63;
`ifdef DIV0_SHORTCUT_EN
            r = 0; z = 1; lat = 1;
`else
            r = n % 8; z = 0; lat = 6;
`endif
        end else begin
            q = n / d; r = n % d; z = 0; lat = 6;
        end
    endfunction

    // Pulse START for one accepting edge, then count edges until DONE (bounded).
    task automatic do_op(input int n, input int d);
        @(negedge CLK);
        N = n[5:0]; D = d[2:0]; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        r_lat = 0;
        while (!DONE && r_lat < 20) begin
            @(posedge CLK); #1;
            r_lat++;
        end
        check("busy_done_exclusive", int'(BUSY && DONE), 0);
        r_q = Q; r_rem = REM; r_div0 = DIV0;
    endtask

    task automatic check_op(input int n, input int d);
        int eq, er, ez, el;
        do_op(n, d);
        model(n, d, eq, er, ez, el);
        check($sformatf("rand_q %0d/%0d", n, d), r_q, eq);
        check($sformatf("rand_rem %0d/%0d", n, d), r_rem, er);
        check($sformatf("rand_div0 %0d/%0d", n, d), r_div0, ez);
        check($sformatf("rand_lat %0d/%0d", n, d), r_lat, el);
    endtask

    initial begin
        int pulses;
        int q_prev;
        int qs, rs;

        vecs[0] = '{45, 6, 7, 3, 0, 6};
        vecs[1] = '{63, 1, 63, 0, 0, 6};
        vecs[2] = '{5, 7, 0, 5, 0, 6};
        vecs[3] = '{0, 3, 0, 0, 0, 6};
        vecs[4] = '{63, 7, 9, 0, 0, 6};
        vecs[5] = '{20, 3, 6, 2, 0, 6};
`ifdef DIV0_SHORTCUT_EN
        vecs[6] = '{42, 0, 63, 0, 1, 1};
`else
        vecs[6] = '{42, 0, 63, 2, 0, 6};
`endif

        // Reset state
        #12;
        check("reset_q", Q, 0);
        check("reset_rem", REM, 0);
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        check("reset_div0", DIV0, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].n, vecs[i].d);
            check($sformatf("vec%0d_q", i), r_q, vecs[i].q);
            check($sformatf("vec%0d_rem", i), r_rem, vecs[i].rem);
            check($sformatf("vec%0d_div0", i), r_div0, vecs[i].div0);
            check($sformatf("vec%0d_lat", i), r_lat, vecs[i].lat);
        end

        // Detailed timing of 45/6: BUSY in cycles 1-6, DONE after edge 6, hold after edge 7
        @(negedge CLK);
        q_prev = Q;
        N = 6'd45; D = 3'd6; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("t_busy_c1", BUSY, 1);
        check("t_done_c1", DONE, 0);
        for (int c = 2; c <= 6; c++) begin
            @(posedge CLK); #1;
            check($sformatf("t_busy_c%0d", c), BUSY, 1);
            check($sformatf("t_done_c%0d", c), DONE, 0);
            check($sformatf("t_qhold_c%0d", c), Q, q_prev);
        end
        @(posedge CLK); #1;
        check("t_done_e6", DONE, 1);
        check("t_busy_e6", BUSY, 0);
        check("t_q_e6", Q, 7);
        check("t_rem_e6", REM, 3);
        check("t_div0_e6", DIV0, 0);
        @(posedge CLK); #1;
        check("t_done_e7", DONE, 0);
        check("t_q_e7", Q, 7);
        check("t_rem_e7", REM, 3);

        // START re-asserted with new operands during RUN cycle 3 is ignored
        @(negedge CLK);
        N = 6'd45; D = 3'd6; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        N = 6'd20; D = 3'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        pulses = 0; qs = -1; rs = -1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            if (DONE) begin
                pulses++;
                if (qs < 0) begin qs = Q; rs = REM; end
            end
        end
        check("ign_pulses", pulses, 1);
        check("ign_q", qs, 7);
        check("ign_rem", rs, 3);

        // Back-to-back: START held through DONE, second accept on the DONE edge
        @(negedge CLK);
        N = 6'd45; D = 3'd6; START = 1'b1;
        @(posedge CLK); #1;
        repeat (5) @(posedge CLK);
        @(posedge CLK); #1;
        check("b2b_done1", DONE, 1);
        check("b2b_q1", Q, 7);
        check("b2b_rem1", REM, 3);
        N = 6'd20; D = 3'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        check("b2b_busy_gap", BUSY, 1);
        check("b2b_done_gap", DONE, 0);
        check("b2b_qhold", Q, 7);
        repeat (5) @(posedge CLK);
        @(posedge CLK); #1;
        check("b2b_done2", DONE, 1);
        check("b2b_q2", Q, 6);
        check("b2b_rem2", REM, 2);

        // Asynchronous reset mid-RUN (cycle 4)
        @(negedge CLK);
        N = 6'd45; D = 3'd6; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("arst_q", Q, 0);
        check("arst_rem", REM, 0);
        check("arst_busy", BUSY, 0);
        check("arst_done", DONE, 0);
        check("arst_div0", DIV0, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) pulses++;
        end
        check("arst_no_done", pulses, 0);
        check_op(20, 3);

        // Exhaustive sweep of nonzero divisors: N = Q*D + REM with REM < D
        for (int n = 0; n < 64; n++) begin
            for (int d = 1; d < 8; d++) begin
                do_op(n, d);
                check($sformatf("ex_ident %0d/%0d", n, d), r_q * d + r_rem, n);
                check($sformatf("ex_remlt %0d/%0d", n, d), int'(r_rem < d), 1);
                check($sformatf("ex_lat %0d/%0d", n, d), r_lat, 6);
            end
        end

        // Randomized operands, including zero divisors
        for (int i = 0; i < 150; i++) begin
            check_op(int'($urandom_range(63)), int'($urandom_range(7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
